// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx among N_REQ byte producers.
// A requester that sends a byte without req_last keeps the grant, so a
// multi-byte message goes out on the line without interleaving.
module uart_tx_arbiter #(
    parameter int unsigned N_REQ    = 4,
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned START_TO = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    input  logic [N_REQ-1:0]          req_last,
    output logic [N_REQ-1:0]          ack,
    output logic [N_REQ-1:0]          sent,
    output logic                      err,
    output logic [DATA_W-1:0]         tx_data,
    output logic                      tx_start,
    input  logic                      tx_busy,
    input  logic                      tx_done
);

    localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned CNT_W = $clog2(START_TO + 1);
    localparam logic [PTR_W:0]   N_REQ_W  = (PTR_W + 1)'(N_REQ);
    localparam logic [PTR_W-1:0] PTR_MAX  = PTR_W'(N_REQ - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(START_TO - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t             state;
    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   owner;
    logic               lock;
    logic               last_lat;
    logic [CNT_W-1:0]   cnt;

    logic [DATA_W-1:0]  bytes [N_REQ];
    logic               pick_valid;
    logic [PTR_W-1:0]   pick_idx;
    logic [PTR_W:0]     scan;

    // Completion is taken from the tx_busy fall; tx_done is informational only.
    logic unused_tx_done;
    assign unused_tx_done = tx_done;

    // Wrap-around increment of a requester index.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_MAX) ? '0 : PTR_W'(p + PTR_W'(1));
    endfunction

    // Split the flat data bus into one byte per requester.
    always_comb begin
        for (int unsigned k = 0; k < N_REQ; k++) begin
            bytes[k] = req_data[k*DATA_W +: DATA_W];
        end
    end

    // Pick: the lock owner only, else first request scanning from rr_ptr.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = rr_ptr;
        scan       = '0;
        if (lock) begin
            pick_valid = req[owner];
            pick_idx   = owner;
        end else begin
            for (int unsigned k = 0; k < N_REQ; k++) begin
                scan = {1'b0, rr_ptr} + (PTR_W + 1)'(k);
                if (scan >= N_REQ_W) begin
                    scan = scan - N_REQ_W;
                end
                if (!pick_valid && req[scan[PTR_W-1:0]]) begin
                    pick_valid = 1'b1;
                    pick_idx   = scan[PTR_W-1:0];
                end
            end
        end
    end

    // Grant FSM with registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            owner    <= '0;
            lock     <= 1'b0;
            last_lat <= 1'b0;
            cnt      <= '0;
            ack      <= '0;
            sent     <= '0;
            err      <= 1'b0;
            tx_data  <= '0;
            tx_start <= 1'b0;
        end else begin
            ack  <= '0;
            sent <= '0;
            case (state)
                IDLE: begin
                    if (!tx_busy && pick_valid) begin
                        tx_data  <= bytes[pick_idx];
                        owner    <= pick_idx;
                        last_lat <= req_last[pick_idx];
                        ack      <= N_REQ'(1) << pick_idx;
                        tx_start <= 1'b1;
                        cnt      <= '0;
                        state    <= START;
                    end
                end
                START: begin
                    if (tx_busy) begin
                        tx_start <= 1'b0;
                        state    <= WAIT;
                    end else if (cnt == CNT_LAST) begin
                        tx_start <= 1'b0;
                        err      <= 1'b1;
                        lock     <= 1'b0;
                        rr_ptr   <= next_ptr(owner);
                        state    <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WAIT: begin
                    if (!tx_busy) begin
                        sent  <= N_REQ'(1) << owner;
                        lock  <= ~last_lat;
                        if (last_lat) begin
                            rr_ptr <= next_ptr(owner);
                        end
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: directed scenarios plus random
// message bursts predicted by a transaction-level arbitration model.
module tb_uart_tx_arbiter;

    localparam int unsigned N   = 4;
    localparam int unsigned DW  = 8;
    localparam int unsigned STO = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      req;
    logic [N*DW-1:0]   req_data;
    logic [N-1:0]      req_last;
    logic [N-1:0]      ack;
    logic [N-1:0]      sent;
    logic              err;
    logic [DW-1:0]     tx_data;
    logic              tx_start;
    logic              tx_busy;
    logic              tx_done;

    logic busy_model   = 1'b0;
    logic busy_foreign = 1'b0;
    assign tx_busy = busy_model | busy_foreign;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.N_REQ(N), .DATA_W(DW), .START_TO(STO)) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data), .req_last(req_last),
        .ack(ack), .sent(sent), .err(err), .tx_data(tx_data), .tx_start(tx_start),
        .tx_busy(tx_busy), .tx_done(tx_done)
    );

    int n_checks = 0;
    int n_pass   = 0;
    bit uart_en  = 1'b0;
    bit hold     = 1'b0;

    logic [DW:0]   rq    [N][$];   // bytes each producer still has to present {last,data}
    logic [DW:0]   stage [N][$];   // same bytes, consumed by the reference model
    int            exp_ack_idx[$];
    logic [DW-1:0] exp_ack_data[$];
    int            exp_sent[$];

    int m_ptr   = 0;
    bit m_lock  = 1'b0;
    int m_owner = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    function automatic int idx_of(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    // Producers: present queue head, advance the cycle after ack.
    initial begin
        req = '0; req_data = '0; req_last = '0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (ack[i] && rq[i].size() > 0) void'(rq[i].pop_front());
                if (!hold && rq[i].size() > 0) begin
                    req[i]               = 1'b1;
                    req_last[i]          = rq[i][0][DW];
                    req_data[i*DW +: DW] = rq[i][0][DW-1:0];
                end else begin
                    req[i] = 1'b0;
                end
            end
        end
    end

    // Transmitter model: busy rises 0..2 cycles after start, lasts 1..5 cycles.
    initial begin
        forever begin
            @(negedge clk);
            if (uart_en && tx_start && !tx_busy && !rst) begin
                repeat ($urandom_range(0, 2)) @(negedge clk);
                busy_model = 1'b1;
                repeat ($urandom_range(1, 5)) @(negedge clk);
                busy_model = 1'b0;
            end
        end
    end

    // Monitor: pop expected grants/completions whenever the DUT pulses them.
    initial begin
        int            ei;
        logic [DW-1:0] ed;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (|ack) begin
                    check("ack_onehot", $countones(ack), 1);
                    check("ack_sent_overlap", ack & sent, 0);
                    if (exp_ack_idx.size() == 0) begin
                        check("ack_unexpected", idx_of(ack), -1);
                    end else begin
                        ei = exp_ack_idx.pop_front();
                        ed = exp_ack_data.pop_front();
                        check("ack_idx", idx_of(ack), ei);
                        check("ack_data", tx_data, ed);
                        check("ack_start", tx_start, 1);
                    end
                end
                if (|sent) begin
                    check("sent_onehot", $countones(sent), 1);
                    if (exp_sent.size() == 0) begin
                        check("sent_unexpected", idx_of(sent), -1);
                    end else begin
                        ei = exp_sent.pop_front();
                        check("sent_idx", idx_of(sent), ei);
                    end
                end
            end
        end
    end

    task automatic push_req(input int i, input logic [DW-1:0] d, input bit last);
        rq[i].push_back({last, d});
    endtask

    task automatic expect_tx(input int i, input logic [DW-1:0] d, input bit done);
        exp_ack_idx.push_back(i);
        exp_ack_data.push_back(d);
        if (done) exp_sent.push_back(i);
    endtask

    // Reference model: round-robin over producers with pending bytes,
    // owner keeps the line until it sends a byte marked last.
    task automatic model_sched();
        int            pick;
        logic [DW:0]   ent;
        forever begin
            pick = -1;
            if (m_lock) begin
                if (stage[m_owner].size() > 0) pick = m_owner;
            end else begin
                for (int k = 0; k < N; k++) begin
                    if (pick < 0 && stage[(m_ptr + k) % N].size() > 0) pick = (m_ptr + k) % N;
                end
            end
            if (pick < 0) break;
            ent = stage[pick].pop_front();
            expect_tx(pick, ent[DW-1:0], 1'b1);
            m_owner = pick;
            if (ent[DW]) begin
                m_lock = 1'b0;
                m_ptr  = (pick + 1) % N;
            end else begin
                m_lock = 1'b1;
            end
        end
    endtask

    task automatic wait_idle(input string name);
        bit done = 1'b0;
        for (int c = 0; c < 3000 && !done; c++) begin
            @(negedge clk);
            done = (exp_ack_idx.size() == 0) && (exp_sent.size() == 0) && !tx_busy && !tx_start;
            for (int i = 0; i < N; i++) if (rq[i].size() > 0) done = 1'b0;
        end
        if (!done) check({name, "_idle_timeout"}, 0, 1);
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_start(input string name);
        int c = 0;
        while (!tx_start && c < 200) begin
            @(negedge clk);
            c++;
        end
        if (!tx_start) check({name, "_start_timeout"}, 0, 1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int i = 0; i < N; i++) begin
            rq[i].delete();
            stage[i].delete();
        end
        m_ptr = 0; m_lock = 1'b0; m_owner = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_ack", ack, 0);
        check("rst_sent", sent, 0);
        check("rst_err", err, 0);
        check("rst_tx_start", tx_start, 0);
        check("rst_tx_data", tx_data, 0);
    endtask

    initial begin
        int          cnt;
        int          np;
        int          len;
        logic [DW-1:0] d;
        rst = 1'b1;
        tx_done = 1'b0;
        uart_en = 1'b1;
        do_reset();

        // Single byte from requester 2
        push_req(2, 8'h41, 1'b1);
        expect_tx(2, 8'h41, 1'b1);
        wait_idle("single");
        check("single_tx_data_held", tx_data, 8'h41);

        // Round-robin with all four requesting: 0,1,2,3,0
        do_reset();
        hold = 1'b1;
        push_req(0, 8'h10, 1'b1); push_req(0, 8'h14, 1'b1);
        push_req(1, 8'h11, 1'b1); push_req(2, 8'h12, 1'b1); push_req(3, 8'h13, 1'b1);
        expect_tx(0, 8'h10, 1'b1); expect_tx(1, 8'h11, 1'b1); expect_tx(2, 8'h12, 1'b1);
        expect_tx(3, 8'h13, 1'b1); expect_tx(0, 8'h14, 1'b1);
        @(negedge clk);
        hold = 1'b0;
        wait_idle("rr");

        // Packet lock: pointer at 1, then 1,1,1,3,0
        do_reset();
        push_req(0, 8'h01, 1'b1);
        expect_tx(0, 8'h01, 1'b1);
        wait_idle("lock_pre");
        hold = 1'b1;
        push_req(1, 8'hA0, 1'b0); push_req(1, 8'hA1, 1'b0); push_req(1, 8'hA2, 1'b1);
        push_req(0, 8'hB0, 1'b1); push_req(3, 8'hC3, 1'b1);
        expect_tx(1, 8'hA0, 1'b1); expect_tx(1, 8'hA1, 1'b1); expect_tx(1, 8'hA2, 1'b1);
        expect_tx(3, 8'hC3, 1'b1); expect_tx(0, 8'hB0, 1'b1);
        @(negedge clk);
        hold = 1'b0;
        wait_idle("lock");

        // Start timeout: no busy ever, then pointer moves past the aborted owner
        do_reset();
        uart_en = 1'b0;
        push_req(1, 8'h55, 1'b1);
        expect_tx(1, 8'h55, 1'b0);
        wait_start("timeout");
        cnt = 0;
        while (tx_start && cnt < STO + 10) begin
            cnt++;
            @(negedge clk);
        end
        check("timeout_start_cycles", cnt, STO);
        check("timeout_err", err, 1);
        repeat (3) @(negedge clk);
        uart_en = 1'b1;
        hold = 1'b1;
        push_req(3, 8'h66, 1'b1); push_req(2, 8'h22, 1'b1);
        expect_tx(2, 8'h22, 1'b1); expect_tx(3, 8'h66, 1'b1);
        @(negedge clk);
        hold = 1'b0;
        wait_idle("timeout_next");
        check("timeout_err_sticky", err, 1);

        // Foreign busy blocks the pick; ack one cycle after busy falls
        busy_foreign = 1'b1;
        push_req(0, 8'h3C, 1'b1);
        expect_tx(0, 8'h3C, 1'b1);
        repeat (4) begin
            @(negedge clk);
            check("fbusy_no_ack", ack, 0);
        end
        busy_foreign = 1'b0;
        @(negedge clk);
        check("fbusy_ack", ack, 4'b0001);
        wait_idle("fbusy");

        // Reset while waiting for busy to fall
        push_req(1, 8'h5A, 1'b1);
        expect_tx(1, 8'h5A, 1'b1);
        wait_idle("mid_pre");
        uart_en = 1'b0;
        push_req(2, 8'h77, 1'b1);
        expect_tx(2, 8'h77, 1'b0);
        wait_start("mid");
        busy_foreign = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_tx_start", tx_start, 0);
        check("mid_rst_ack", ack, 0);
        check("mid_rst_sent", sent, 0);
        check("mid_rst_err", err, 0);
        hold = 1'b1;
        push_req(3, 8'h33, 1'b1); push_req(1, 8'h31, 1'b1);
        expect_tx(1, 8'h31, 1'b1); expect_tx(3, 8'h33, 1'b1);
        @(negedge clk);
        hold = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("mid_busy_no_ack", ack, 0);
        end
        busy_foreign = 1'b0;
        uart_en = 1'b1;
        wait_idle("mid_post");

        // Random message bursts against the reference model
        do_reset();
        for (int r = 0; r < 25; r++) begin
            hold = 1'b1;
            for (int i = 0; i < N; i++) begin
                np = $urandom_range(0, 2);
                for (int p = 0; p < np; p++) begin
                    len = $urandom_range(1, 3);
                    for (int b = 0; b < len; b++) begin
                        d = DW'($urandom);
                        rq[i].push_back({(b == len - 1) ? 1'b1 : 1'b0, d});
                        stage[i].push_back({(b == len - 1) ? 1'b1 : 1'b0, d});
                    end
                end
            end
            model_sched();
            @(negedge clk);
            hold = 1'b0;
            wait_idle("random");
        end
        check("random_err_clear", err, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
